// File: rtl/newhope_pkg.sv
// Shared encodings and sizing helpers for the input-buffer fill stage.
package newhope_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_LAST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Stream beats packed into one RAM word.
    function automatic int calc_beats(input int mem_width, input int in_width);
        return mem_width / in_width;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ram_stream_loader.sv
// Packs a narrow valid/ready stream into RAM words, writes MEM_SIZE words from address 0,
// then hands the RAM port to the downstream read interface.
module ram_stream_loader
    import newhope_pkg::*;
#(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_SIZE  = 24,
    parameter int IN_WIDTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [IN_WIDTH-1:0]         din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic                        done,
    input  logic                        rd_en,
    input  logic [$clog2(MEM_SIZE)-1:0] rd_addr,
    output logic                        ram_en,
    output logic                        ram_we,
    output logic [$clog2(MEM_SIZE)-1:0] ram_addr,
    output logic [MEM_WIDTH-1:0]        ram_di
);

    localparam int BEATS = calc_beats(MEM_WIDTH, IN_WIDTH);
    localparam int AW    = $clog2(MEM_SIZE);
    localparam int BW    = cnt_width(BEATS);

    generate
        if ((MEM_WIDTH % IN_WIDTH) != 0) begin : g_bad_width
            $error("MEM_WIDTH must be an integer multiple of IN_WIDTH");
        end
        if (MEM_SIZE < 2) begin : g_bad_size
            $error("MEM_SIZE must be at least 2");
        end
    endgenerate

    state_t                state_reg;
    state_t                state_next;
    logic [BW-1:0]         beat_cnt_reg;
    logic [AW-1:0]         word_cnt_reg;
    logic [MEM_WIDTH-1:0]  pack_reg;
    logic [MEM_WIDTH-1:0]  pack_next;
    logic                  wr_en_reg;
    logic [AW-1:0]         wr_addr_reg;
    logic [MEM_WIDTH-1:0]  wr_data_reg;

    logic start_load;
    logic accept;
    logic last_beat;
    logic last_word;

    assign start_load = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign accept     = din_valid && (state_reg == ST_LOAD);
    assign last_beat  = (beat_cnt_reg == BW'(BEATS - 1));
    assign last_word  = (word_cnt_reg == AW'(MEM_SIZE - 1));

    // Current beat merged into the partial word; earlier beats sit below it.
    always_comb begin
        pack_next = pack_reg;
        pack_next[int'(beat_cnt_reg) * IN_WIDTH +: IN_WIDTH] = din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        din_ready  = 1'b0;
        done       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                din_ready = 1'b1;
                if (accept && last_beat && last_word) state_next = ST_LAST;
            end
            ST_LAST: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_next = ST_LOAD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Write strobe lives for exactly one cycle after the completing beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_reg <= '0;
            word_cnt_reg <= '0;
            pack_reg     <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            wr_en_reg <= 1'b0;
            if (start_load) begin
                beat_cnt_reg <= '0;
                word_cnt_reg <= '0;
                pack_reg     <= '0;
            end else if (accept) begin
                pack_reg <= pack_next;
                if (last_beat) begin
                    beat_cnt_reg <= '0;
                    wr_en_reg    <= 1'b1;
                    wr_addr_reg  <= word_cnt_reg;
                    wr_data_reg  <= pack_next;
                    if (!last_word) word_cnt_reg <= word_cnt_reg + 1'b1;
                end else begin
                    beat_cnt_reg <= beat_cnt_reg + 1'b1;
                end
            end
        end
    end

    // The read side only owns the port once the buffer is complete.
    always_comb begin
        ram_di = wr_data_reg;
        if (state_reg == ST_DONE) begin
            ram_en   = rd_en;
            ram_we   = 1'b0;
            ram_addr = rd_addr;
        end else begin
            ram_en   = wr_en_reg;
            ram_we   = wr_en_reg;
            ram_addr = wr_addr_reg;
        end
    end

endmodule

// File: tb/tb_ram_stream_loader.sv
// Directed bench for ram_stream_loader with a behavioural single-port RAM beside the DUT.
module tb_ram_stream_loader;

    localparam int MW = 32;
    localparam int MS = 24;
    localparam int IW = 8;
    localparam int AW = $clog2(MS);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [IW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic          done;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [MW-1:0] ram_di;

    logic [MW-1:0] ram_mem [0:MS-1];
    logic [MW-1:0] ram_dout;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_count = 0;
    int rd_count = 0;

    typedef struct {
        string         name;
        int            addr;
        logic [MW-1:0] exp;
    } img_vec_t;

    img_vec_t vec1 [5];
    img_vec_t vec4 [4];

    ram_stream_loader #(.MEM_WIDTH(MW), .MEM_SIZE(MS), .IN_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_di;
            ram_dout <= ram_mem[ram_addr];
        end
    end

    always @(posedge clk) begin
        if (ram_en && ram_we) wr_count <= wr_count + 1;
        if (ram_en && !ram_we && !done) rd_count <= rd_count + 1;
    end

    task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Pushes n bytes; byte value is offset+index, or 0xFF when ff is set.
    task automatic stream(input int n, input int offset, input bit ff, input bit rnd);
        int acc = 0;
        int guard = 0;
        while (acc < n && guard < 2000) begin
            @(negedge clk);
            din_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            din = ff ? 8'hFF : 8'(offset + acc);
            if (din_valid && din_ready) acc++;
            guard++;
        end
        if (acc < n) check("stream_timeout", 32'(acc), 32'(n));
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic check_last_then_done(input string tag);
        // Called on the negedge right after the final beat's edge.
        check({tag, "_last_done"}, 32'(done), 32'd0);
        check({tag, "_last_ready"}, 32'(din_ready), 32'd0);
        check({tag, "_last_we"}, 32'(ram_we), 32'd1);
        check({tag, "_last_addr"}, 32'(ram_addr), 32'd23);
        @(negedge clk);
        check({tag, "_done_rise"}, 32'(done), 32'd1);
    endtask

    initial begin
        int w0;
        int r0;

        vec1[0] = '{"img1_w0",  0,  32'h03020100};
        vec1[1] = '{"img1_w5",  5,  32'h17161514};
        vec1[2] = '{"img1_w11", 11, 32'h2F2E2D2C};
        vec1[3] = '{"img1_w12", 12, 32'h33323130};
        vec1[4] = '{"img1_w23", 23, 32'h5F5E5D5C};
        vec4[0] = '{"img4_w0",  0,  32'h03020100};
        vec4[1] = '{"img4_w11", 11, 32'h2F2E2D2C};
        vec4[2] = '{"img4_w12", 12, 32'hFFFFFFFF};
        vec4[3] = '{"img4_w23", 23, 32'hFFFFFFFF};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(din_ready), 32'd0);
        check("rst_en", 32'(ram_en), 32'd0);
        check("rst_di", ram_di, 32'd0);
        rst_n = 1'b1;

        // 1: continuous stream
        w0 = wr_count;
        pulse_start();
        check("t1_ready_in_load", 32'(din_ready), 32'd1);
        stream(96, 0, 1'b0, 1'b0);
        check_last_then_done("t1");
        check("t1_strobes", 32'(wr_count - w0), 32'd24);
        foreach (vec1[i]) check(vec1[i].name, ram_mem[vec1[i].addr], vec1[i].exp);

        // 6a: valid in DONE is ignored
        w0 = wr_count;
        din_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_done_ready", 32'(din_ready), 32'd0);
        din_valid = 1'b0;
        check("t6_done_writes", 32'(wr_count - w0), 32'd0);

        // 3: read port in DONE
        rd_en = 1'b1; rd_addr = 5'd5;
        #1;
        check("t3_rd_en", 32'(ram_en), 32'd1);
        check("t3_rd_we", 32'(ram_we), 32'd0);
        check("t3_rd_addr", 32'(ram_addr), 32'd5);
        @(negedge clk);
        check("t3_dout", ram_dout, 32'h17161514);
        rd_en = 1'b0;

        // 2: random valid reload, with rd_en held through the load
        w0 = wr_count; r0 = rd_count;
        pulse_start();
        check("t2_done_drop", 32'(done), 32'd0);
        rd_en = 1'b1; rd_addr = 5'd3;
        stream(96, 0, 1'b0, 1'b1);
        check_last_then_done("t2");
        rd_en = 1'b0;
        check("t2_strobes", 32'(wr_count - w0), 32'd24);
        check("t2_no_reads", 32'(rd_count - r0), 32'd0);
        foreach (vec1[i]) check({"t2_", vec1[i].name}, ram_mem[vec1[i].addr], vec1[i].exp);

        // 5: start during LOAD is ignored
        w0 = wr_count;
        pulse_start();
        stream(10, 0, 1'b0, 1'b0);
        pulse_start();
        check("t5_still_load", 32'(din_ready), 32'd1);
        stream(86, 10, 1'b0, 1'b0);
        check_last_then_done("t5");
        check("t5_strobes", 32'(wr_count - w0), 32'd24);
        check("t5_w23", ram_mem[23], 32'h5F5E5D5C);

        // 5b: reload with 0xFF
        pulse_start();
        check("t5b_done_drop", 32'(done), 32'd0);
        stream(96, 0, 1'b1, 1'b0);
        check_last_then_done("t5b");
        for (int k = 0; k < MS; k++) begin
            if (ram_mem[k] !== 32'hFFFFFFFF) check("t5b_ff_word", ram_mem[k], 32'hFFFFFFFF);
        end
        check("t5b_ff_w7", ram_mem[7], 32'hFFFFFFFF);

        // 4: reset after 50 bytes
        w0 = wr_count;
        pulse_start();
        stream(50, 0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_ready", 32'(din_ready), 32'd0);
        check("t4_rst_en", 32'(ram_en), 32'd0);
        check("t4_rst_addr", 32'(ram_addr), 32'd0);
        check("t4_rst_di", ram_di, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t4_strobes", 32'(wr_count - w0), 32'd12);
        foreach (vec4[i]) check(vec4[i].name, ram_mem[vec4[i].addr], vec4[i].exp);

        // 6b: valid in IDLE is ignored
        w0 = wr_count;
        din_valid = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_idle_ready", 32'(din_ready), 32'd0);
        check("t6_idle_done", 32'(done), 32'd0);
        din_valid = 1'b0;
        check("t6_idle_writes", 32'(wr_count - w0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
